mod_addsub_ctrl: RTL and testbench

//   Sequencer computing (A + B) mod M or (A - B) mod M on the shared mpadder.

---
 rtl/mod_addsub_ctrl.sv | 154 +++++++++++++++
 tb/tb_mod_addsub_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_addsub_ctrl.sv
// Modular add/subtract sequencer: drives a shared mpadder for a raw add/sub pass
// followed by an optional correction pass by M, returning (A +/- B) mod M.
module mod_addsub_ctrl #(
  parameter int WIDTH = 1027
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             add_start,
  output logic             add_subtract,
  output logic [WIDTH-1:0] add_in_a,
  output logic [WIDTH-1:0] add_in_b,
  input  logic [WIDTH:0]   add_result,
  input  logic             add_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_P1_GO   = 3'd1,
    S_P1_WAIT = 3'd2,
    S_P2_GO   = 3'd3,
    S_P2_WAIT = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] m_r, m_s;
  logic [WIDTH-1:0] t_r, t_s;
  logic             sub_r, sub_s;
  logic [WIDTH-1:0] result_s, add_in_a_s, add_in_b_s;
  logic             done_s, busy_s, add_start_s, add_subtract_s;

  // Next-state and next-output logic; outputs are registered one cycle later.
  always_comb begin
    state_s        = state_r;
    m_s            = m_r;
    t_s            = t_r;
    sub_s          = sub_r;
    result_s       = result;
    done_s         = 1'b0;
    busy_s         = busy;
    add_start_s    = 1'b0;
    add_subtract_s = add_subtract;
    add_in_a_s     = add_in_a;
    add_in_b_s     = add_in_b;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s        = S_P1_GO;
          m_s            = in_m;
          sub_s          = subtract;
          add_in_a_s     = in_a;
          add_in_b_s     = in_b;
          add_subtract_s = subtract;
          add_start_s    = 1'b1;
          busy_s         = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_P1_GO: begin
        state_s = S_P1_WAIT;
      end
      S_P1_WAIT: begin
        if (add_done) begin
          t_s = add_result[WIDTH-1:0];
          // A subtraction that did not borrow is already reduced.
          if (!sub_r || add_result[WIDTH]) begin
            state_s        = S_P2_GO;
            add_in_a_s     = add_result[WIDTH-1:0];
            add_in_b_s     = m_r;
            add_subtract_s = !sub_r;
            add_start_s    = 1'b1;
          end else begin
            state_s  = S_FIN;
            result_s = add_result[WIDTH-1:0];
            done_s   = 1'b1;
            busy_s   = 1'b0;
          end
        end else begin
          state_s = S_P1_WAIT;
        end
      end
      S_P2_GO: begin
        state_s = S_P2_WAIT;
      end
      S_P2_WAIT: begin
        if (add_done) begin
          state_s = S_FIN;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          // For add, a borrow on S-M means S was already below M.
          if (!sub_r && add_result[WIDTH]) begin
            result_s = t_r;
          end else begin
            result_s = add_result[WIDTH-1:0];
          end
        end else begin
          state_s = S_P2_WAIT;
        end
      end
      S_FIN: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latches and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_r          <= {WIDTH{1'b0}};
      t_r          <= {WIDTH{1'b0}};
      sub_r        <= 1'b0;
      result       <= {WIDTH{1'b0}};
      done         <= 1'b0;
      busy         <= 1'b0;
      add_start    <= 1'b0;
      add_subtract <= 1'b0;
      add_in_a     <= {WIDTH{1'b0}};
      add_in_b     <= {WIDTH{1'b0}};
    end else begin
      m_r          <= m_s;
      t_r          <= t_s;
      sub_r        <= sub_s;
      result       <= result_s;
      done         <= done_s;
      busy         <= busy_s;
      add_start    <= add_start_s;
      add_subtract <= add_subtract_s;
      add_in_a     <= add_in_a_s;
      add_in_b     <= add_in_b_s;
    end
  end

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Scoreboard bench for mod_addsub_ctrl with a behavioural mpadder of random latency.
module tb_mod_addsub_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start, subtract;
  logic [W-1:0] in_a, in_b, in_m;
  logic [W-1:0] result;
  logic         done, busy, add_start, add_subtract;
  logic [W-1:0] add_in_a, add_in_b;
  logic [W:0]   add_result;
  logic         add_done;

  mod_addsub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .subtract(subtract),
    .in_a(in_a), .in_b(in_b), .in_m(in_m), .result(result), .done(done),
    .busy(busy), .add_start(add_start), .add_subtract(add_subtract),
    .add_in_a(add_in_a), .add_in_b(add_in_b), .add_result(add_result),
    .add_done(add_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    int           passes;
    int           base;
    logic         p2_sub;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   ops_issued = 0;
  int   ops_done = 0;

  // mpadder model: random completion latency, never reset.
  int           starts_total = 0;
  int           pend = 0;
  int           force_delay = 0;
  logic [W-1:0] cap_a, cap_b;
  logic         cap_sub;

  initial begin
    add_done   = 1'b0;
    add_result = '0;
  end

  always @(negedge clk) begin
    add_done <= 1'b0;
    if (pend > 0) begin
      if (pend == 1) begin
        add_done   <= 1'b1;
        add_result <= cap_sub ? ({1'b0, cap_a} - {1'b0, cap_b}) : ({1'b0, cap_a} + {1'b0, cap_b});
      end
      pend <= pend - 1;
    end
    if (add_start === 1'b1) begin
      starts_total <= starts_total + 1;
      cap_a        <= add_in_a;
      cap_b        <= add_in_b;
      cap_sub      <= add_subtract;
      pend         <= (force_delay > 0) ? force_delay : int'($urandom_range(4, 1));
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic issue(input logic sub, input int a, input int b, input int m,
                       input string name, input bit expect_it);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    subtract = sub;
    in_a     = W'(a);
    in_b     = W'(b);
    in_m     = W'(m);
    if (expect_it) begin
      e.name   = name;
      e.res    = sub ? W'((a - b + m) % m) : W'((a + b) % m);
      e.passes = (sub && a >= b) ? 1 : 2;
      e.base   = starts_total;
      e.p2_sub = !sub;
      sb.push_back(e);
      ops_issued++;
    end
    @(negedge clk);
    start = 1'b0;
    in_a  = W'($urandom);
    in_b  = W'($urandom);
    in_m  = W'($urandom);
    chk({name, "_busy"}, longint'(busy), 64'd1);
  endtask

  task automatic wait_ops(input string name);
    int k;
    k = 0;
    while (ops_done != ops_issued && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (ops_done != ops_issued) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: completed %0d of %0d operations", name, ops_done, ops_issued);
      ops_done = ops_issued;
      sb.delete();
    end
  endtask

  initial begin
    resetn   = 1'b0;
    start    = 1'b0;
    subtract = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_m     = '0;
    fork
      // Monitor: pops the scoreboard whenever the DUT signals done.
      forever begin
        exp_t e;
        @(negedge clk);
        if (done === 1'b1) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: result=%0d with nothing outstanding", result);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_result"}, longint'(result), longint'(e.res));
            chk({e.name, "_passes"}, longint'(starts_total - e.base), longint'(e.passes));
            chk({e.name, "_busy_at_done"}, longint'(busy), 64'd0);
            if (e.passes == 2)
              chk({e.name, "_pass2_sub"}, longint'(cap_sub), longint'(e.p2_sub));
            else
              chk({e.name, "_single_pass_sub"}, longint'(cap_sub), 64'd1);
            ops_done++;
          end
        end
      end
      begin
        repeat (3) @(negedge clk);
        chk("rst_result", longint'(result), 64'd0);
        chk("rst_ctrl", longint'({done, busy, add_start, add_subtract}), 64'd0);
        chk("rst_add_a", longint'(add_in_a), 64'd0);
        chk("rst_add_b", longint'(add_in_b), 64'd0);
        resetn = 1'b1;

        issue(1'b0, 5, 7, 11, "add_5_7", 1'b1);   wait_ops("add_5_7");
        issue(1'b0, 10, 1, 11, "add_s_eq_m", 1'b1); wait_ops("add_s_eq_m");
        issue(1'b0, 0, 0, 11, "add_0_0", 1'b1);   wait_ops("add_0_0");
        issue(1'b1, 3, 8, 11, "sub_3_8", 1'b1);   wait_ops("sub_3_8");
        issue(1'b1, 8, 3, 11, "sub_8_3", 1'b1);   wait_ops("sub_8_3");
        issue(1'b1, 4, 4, 11, "sub_4_4", 1'b1);   wait_ops("sub_4_4");

        // Second start while the first pass is outstanding must be ignored.
        force_delay = 5;
        issue(1'b0, 5, 7, 11, "add_busy_start", 1'b1);
        @(negedge clk);
        start = 1'b1; subtract = 1'b1; in_a = W'(1); in_b = W'(1); in_m = W'(3);
        @(negedge clk);
        start = 1'b0;
        wait_ops("add_busy_start");

        // Reset during the second pass; the late add_done must be ignored.
        force_delay = 6;
        begin
          int base, k;
          base = starts_total;
          issue(1'b0, 5, 7, 11, "rst_mid", 1'b0);
          k = 0;
          while (starts_total < base + 2 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
          end
          chk("rst_mid_reached_p2", longint'(starts_total - base), 64'd2);
        end
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rst_mid_result", longint'(result), 64'd0);
        chk("rst_mid_ctrl", longint'({done, busy, add_start, add_subtract}), 64'd0);
        chk("rst_mid_operands", longint'({add_in_a, add_in_b}), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_mid_idle_busy", longint'(busy), 64'd0);
        force_delay = 0;
        issue(1'b0, 1, 1, 11, "after_rst", 1'b1); wait_ops("after_rst");

        for (int i = 0; i < 40; i++) begin
          int m, a, b;
          m = int'($urandom_range(32767, 2));
          a = int'($urandom_range(m - 1, 0));
          b = int'($urandom_range(m - 1, 0));
          issue(1'($urandom_range(1, 0)), a, b, m, "rand", 1'b1);
          wait_ops("rand");
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
      end
    join
  end
endmodule
